// File: rtl/alu_seq_if.sv
// alu_seq request/response bundle.
// Input valid/ready handshake, output valid/ready handshake, status flags.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             busy;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, result, zero, carry, ovf, busy
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, result, zero, carry, ovf, busy
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops plus an iterative radix-2 Booth multiply.
// Results and flags are registered and held until the consumer takes them.
module alu_seq #(
    parameter int WIDTH = 32
) (
    input logic   clk,
    input logic   rst_n,
    alu_seq_if.slave bus
);
    localparam int MUL_W = WIDTH / 2;
    localparam int SH_W  = $clog2(WIDTH);
    localparam int CNT_W = $clog2(MUL_W + 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_XOR = 4'b0011;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SLL = 4'b1000;
    localparam logic [3:0] OP_SRL = 4'b1001;
    localparam logic [3:0] OP_SRA = 4'b1010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [MUL_W:0]   acc;
    logic [MUL_W:0]   m;
    logic [MUL_W-1:0] q;
    logic             q_m1;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] result;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             out_valid;

    logic             in_ready;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SH_W-1:0]  sh;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
    logic             is_mul;

    logic [MUL_W:0]   acc_n;
    logic [MUL_W:0]   acc_s;
    logic [MUL_W-1:0] q_s;
    logic             q_m1_s;
    logic [WIDTH-1:0] prod;

    assign in_ready = (state == IDLE);
    assign is_mul   = (bus.sel == OP_MUL);
    assign sh       = bus.b[SH_W-1:0];
    assign sum      = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff     = {1'b0, bus.a} - {1'b0, bus.b};

    // Single-cycle datapath; evaluated on the accept edge only.
    always_comb begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.sel)
            OP_AND: alu_res = bus.a & bus.b;
            OP_OR:  alu_res = bus.a | bus.b;
            OP_XOR: alu_res = bus.a ^ bus.b;
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = ~diff[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_SLT: begin
                alu_res = '0;
                alu_res[0] = ($signed(bus.a) < $signed(bus.b));
            end
            OP_SLL: alu_res = bus.a << sh;
            OP_SRL: alu_res = bus.a >> sh;
            OP_SRA: alu_res = $signed(bus.a) >>> sh;
            OP_MUL: alu_res = '0;
            default: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
        endcase
    end

    // One Booth step: add/sub M by {Q0,Q-1}, then arithmetic shift right.
    always_comb begin
        acc_n = acc;
        case ({q[0], q_m1})
            2'b10:   acc_n = acc - m;
            2'b01:   acc_n = acc + m;
            default: acc_n = acc;
        endcase
        acc_s  = {acc_n[MUL_W], acc_n[MUL_W:1]};
        q_s    = {acc_n[0], q[MUL_W-1:1]};
        q_m1_s = q[0];
        prod   = {acc_s[MUL_W-1:0], q_s};
    end

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            m         <= '0;
            q         <= '0;
            q_m1      <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && in_ready) begin
                        if (is_mul) begin
                            m     <= {bus.a[MUL_W-1], bus.a[MUL_W-1:0]};
                            q     <= bus.b[MUL_W-1:0];
                            q_m1  <= 1'b0;
                            acc   <= '0;
                            cnt   <= CNT_W'(MUL_W);
                            state <= MUL;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            carry     <= alu_c;
                            ovf       <= alu_v;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                MUL: begin
                    acc  <= acc_s;
                    q    <= q_s;
                    q_m1 <= q_m1_s;
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        result    <= prod;
                        zero      <= (prod == '0);
                        carry     <= 1'b0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.busy      = (state != IDLE);
    assign bus.out_valid = out_valid;
    assign bus.result    = result;
    assign bus.zero      = zero;
    assign bus.carry     = carry;
    assign bus.ovf       = ovf;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized bench for alu_seq against a plain-arithmetic reference model.
// Directed cases cover carry/overflow edges, Booth extremes, hold and reset.
module tb_alu_seq;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    alu_seq_if #(.WIDTH(32)) bus ();

    alu_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {result, zero, carry, ovf}.
    function automatic logic [34:0] model(input logic [3:0] s,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx;
        longint sy;
        longint ux;
        longint uy;
        longint full;
        logic [31:0] r;
        logic c;
        logic v;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'b0, x});
        uy = longint'({32'b0, y});
        c = 1'b0;
        v = 1'b0;
        case (s)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0011: r = x ^ y;
            4'b0110: begin
                full = sx - sy;
                r = x - y;
                c = (x >= y);
                v = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
            4'b0100: begin
                full = longint'($signed(x[15:0])) * longint'($signed(y[15:0]));
                r = full[31:0];
            end
            4'b0111: r = (sx < sy) ? 32'd1 : 32'd0;
            4'b1000: r = x << y[4:0];
            4'b1001: r = x >> y[4:0];
            4'b1010: r = $signed(x) >>> y[4:0];
            default: begin
                full = sx + sy;
                r = x + y;
                c = (ux + uy) > 64'sd4294967295;
                v = (full > 64'sd2147483647) || (full < -64'sd2147483648);
            end
        endcase
        return {r, (r == 32'd0), c, v};
    endfunction

    task automatic run_op(input logic [3:0] s, input logic [31:0] x,
                          input logic [31:0] y, input int hold);
        logic [34:0] exp;
        int lat;
        int busy_n;
        int bad;
        exp = model(s, x, y);
        @(negedge clk);
        chk("in_ready_idle", bus.in_ready, 1);
        bus.in_valid  = 1'b1;
        bus.sel       = s;
        bus.a         = x;
        bus.b         = y;
        bus.out_ready = 1'b0;
        lat = 0;
        busy_n = 0;
        bad = 0;
        do begin
            @(negedge clk);
            lat++;
            bus.in_valid = 1'b0;
            bus.a   = $urandom;
            bus.b   = $urandom;
            bus.sel = 4'($urandom);
            if (bus.busy) busy_n++;
            if (bus.in_ready) bad++;
        end while (!bus.out_valid && lat < 40);
        chk("latency", lat, (s == 4'b0100) ? 17 : 1);
        chk("result", bus.result, exp[34:3]);
        chk("zero", bus.zero, exp[2]);
        chk("carry", bus.carry, exp[1]);
        chk("ovf", bus.ovf, exp[0]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom);
            bus.a   = $urandom;
            bus.sel = 4'($urandom);
            if ({bus.result, bus.zero, bus.carry, bus.ovf} !== exp) bad++;
            if (bus.in_ready || !bus.out_valid) bad++;
            if (bus.busy) busy_n++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("back_idle", bus.in_ready, 1);
        chk("out_valid_drop", bus.out_valid, 0);
        chk("busy_cycles", busy_n, lat + hold);
        chk("handshake", bad, 0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h7FFF_FFFF;
            4: return {$urandom_range(0, 1) ? 16'h8000 : 16'h7FFF, 16'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a   = '0;
        bus.b   = '0;
        bus.sel = '0;
        #1;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_flags", {bus.zero, bus.carry, bus.ovf}, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_busy", bus.busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 0);
        run_op(4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op(4'b0110, 32'd5, 32'd7, 0);
        run_op(4'b0110, 32'd7, 32'd7, 0);
        run_op(4'b0111, 32'hFFFF_FFFF, 32'd1, 0);
        run_op(4'b0100, 32'hABCD_FFFD, 32'h1234_0007, 0);
        run_op(4'b0100, 32'h0000_8000, 32'h0000_8000, 0);
        run_op(4'b1010, 32'h8000_0000, 32'h0000_0024, 0);
        run_op(4'b1001, 32'h8000_0000, 32'h0000_0024, 0);
        run_op(4'b1000, 32'h0000_0001, 32'd31, 0);
        run_op(4'b1010, 32'h8000_0000, 32'd0, 0);
        run_op(4'b0110, 32'h8000_0000, 32'h0000_0001, 5);
        run_op(4'b0100, 32'h0000_7FFF, 32'h0000_8000, 5);

        for (int i = 0; i < 150; i++) begin
            run_op(4'($urandom), pick(), pick(), $urandom_range(0, 2));
        end

        run_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, 0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.sel = 4'b0100;
        bus.a   = 32'h0000_1234;
        bus.b   = 32'h0000_0567;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_result", bus.result, 0);
        chk("midrst_flags", {bus.zero, bus.carry, bus.ovf}, 0);
        chk("midrst_busy", bus.busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.out_valid) quiet++;
        end
        chk("no_stale_valid", quiet, 0);
        run_op(4'b0010, 32'd2, 32'd3, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
